// File: rtl/pulse_seq_mc.sv
`default_nettype none
// ============================================================================
// Module   : pulse_seq_mc
// Brief    : NUM_CH independent pulse generators sharing one arm/fire/abort
//            control, programmed through a simple register strobe interface.
//            Optional ARMED-state timeout: define PULSE_SEQ_ARM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_seq_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int ARM_TIMEOUT = 100000000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pulse_out,
  output logic              busy,
  output logic              done_irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;
  typedef enum logic [2:0] {CH_IDLE = 3'd0, CH_DLY = 3'd1, CH_HI = 3'd2,
                            CH_LO = 3'd3, CH_DONE = 3'd4} ch_state_t;

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [31:0]      c_info         = {16'h0002, 8'(CNT_W), 8'(NUM_CH)};
  localparam logic [31:0]      c_arm_timeout  = 32'(ARM_TIMEOUT);

  state_t            r_state;
  logic              r_done;
  logic              r_aborted;
  logic              r_timeout;
  logic [NUM_CH-1:0] r_ch_en;
  logic [CNT_W-1:0]  r_dly [NUM_CH];
  logic [CNT_W-1:0]  r_wid [NUM_CH];
  logic [CNT_W-1:0]  r_per [NUM_CH];
  logic [CNT_W-1:0]  r_rep [NUM_CH];
  logic [NUM_CH-1:0] w_ch_done;

  logic w_ctrl_wr, w_arm, w_fire, w_abort, w_fire_go, w_run_end, w_locked;
  assign w_ctrl_wr = wr_en && (wr_addr == 8'h00);
  assign w_arm     = w_ctrl_wr && wr_data[0];
  assign w_fire    = w_ctrl_wr && wr_data[1];
  assign w_abort   = w_ctrl_wr && wr_data[2];
  assign w_fire_go = (r_state == ARMED) && w_fire && !w_abort;
  assign w_run_end = (r_state == RUN) && (&w_ch_done);
  assign w_locked  = (r_state != IDLE);

  // Channel c occupies the 16-byte window at 0x10 + 0x10*c.
  logic [3:0] w_wr_ch, w_rd_ch;
  logic       w_wr_ch_ok, w_rd_ch_ok;
  assign w_wr_ch    = wr_addr[7:4] - 4'd1;
  assign w_rd_ch    = rd_addr[7:4] - 4'd1;
  assign w_wr_ch_ok = (wr_addr[7:4] != 4'd0) && (5'(w_wr_ch) < 5'(NUM_CH)) && (wr_addr[1:0] == 2'b00);
  assign w_rd_ch_ok = (rd_addr[7:4] != 4'd0) && (5'(w_rd_ch) < 5'(NUM_CH)) && (rd_addr[1:0] == 2'b00);

`ifdef PULSE_SEQ_ARM_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_to_expire;
  assign w_to_expire = (r_state == ARMED) && (r_to_cnt == c_arm_timeout - 32'd1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                r_to_cnt <= '0;
    else if (r_state != ARMED) r_to_cnt <= '0;
    else                       r_to_cnt <= r_to_cnt + 32'd1;
  end
`else
  logic w_to_expire;
  logic w_unused_timeout;
  assign w_to_expire      = 1'b0;
  assign w_unused_timeout = ^c_arm_timeout;
`endif

  // Configuration registers; CTRL writes are consumed by the FSM below.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_err  <= 1'b0;
      r_ch_en <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_dly[c] <= '0;
        r_wid[c] <= '0;
        r_per[c] <= '0;
        r_rep[c] <= '0;
      end
    end else begin
      wr_err <= 1'b0;
      if (wr_en && (wr_addr != 8'h00)) begin
        if ((wr_addr == 8'h08) && !w_locked) begin
          r_ch_en <= wr_data[NUM_CH-1:0];
        end else if (w_wr_ch_ok && !w_locked) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_ch == 4'(c)) begin
              case (wr_addr[3:2])
                2'd0:    r_dly[c] <= CNT_W'(wr_data);
                2'd1:    r_wid[c] <= CNT_W'(wr_data);
                2'd2:    r_per[c] <= CNT_W'(wr_data);
                default: r_rep[c] <= CNT_W'(wr_data);
              endcase
            end
          end
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

  logic [31:0] w_rd_mux;
  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      8'h04: w_rd_mux = {27'd0, r_timeout, r_aborted, r_done, r_state == RUN, r_state == ARMED};
      8'h08: w_rd_mux = 32'(r_ch_en);
      8'h0C: w_rd_mux = c_info;
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_rd_ch_ok && (w_rd_ch == 4'(c))) begin
            case (rd_addr[3:2])
              2'd0:    w_rd_mux = 32'(r_dly[c]);
              2'd1:    w_rd_mux = 32'(r_wid[c]);
              2'd2:    w_rd_mux = 32'(r_per[c]);
              default: w_rd_mux = 32'(r_rep[c]);
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? w_rd_mux : 32'd0;
    end
  end

  // Global sequencer; ABORT overrides every other control bit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= IDLE;
      busy      <= 1'b0;
      done_irq  <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      done_irq <= 1'b0;
      if (w_abort) begin
        if (r_state != IDLE) r_aborted <= 1'b1;
        r_state <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_arm) begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_timeout <= 1'b0;
            if (|r_ch_en) r_state <= ARMED;
          end
          ARMED: if (w_fire) begin
            r_state <= RUN;
            busy    <= 1'b1;
          end else if (w_to_expire) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end
          RUN: if (w_run_end) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            r_done   <= 1'b1;
            done_irq <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_t        r_cs;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_left;
    logic [CNT_W-1:0] w_lo_load;
    logic             r_pulse;

    // Low phase length minus one; PERIOD<=WIDTH collapses to a single low cycle.
    assign w_lo_load    = (r_per[c] <= r_wid[c]) ? '0 : (r_per[c] - r_wid[c] - c_one);
    assign pulse_out[c] = r_pulse;
    assign w_ch_done[c] = (r_cs == CH_DONE);

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_cs    <= CH_IDLE;
        r_cnt   <= '0;
        r_left  <= '0;
        r_pulse <= 1'b0;
      end else if (w_abort || w_run_end) begin
        r_cs    <= CH_IDLE;
        r_pulse <= 1'b0;
      end else if (w_fire_go) begin
        r_pulse <= 1'b0;
        if (r_ch_en[c]) begin
          r_cs   <= CH_DLY;
          r_cnt  <= r_dly[c];
          r_left <= (r_rep[c] == '0) ? c_one : r_rep[c];
        end else begin
          r_cs <= CH_DONE;
        end
      end else begin
        case (r_cs)
          CH_DLY: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_one;
            end else if (r_wid[c] == '0) begin
              r_cs <= CH_DONE;
            end else begin
              r_cs    <= CH_HI;
              r_pulse <= 1'b1;
              r_cnt   <= r_wid[c] - c_one;
            end
          end
          CH_HI: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_one;
            end else begin
              r_pulse <= 1'b0;
              if (r_left <= c_one) begin
                r_cs <= CH_DONE;
              end else begin
                r_cs   <= CH_LO;
                r_cnt  <= w_lo_load;
                r_left <= r_left - c_one;
              end
            end
          end
          CH_LO: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_one;
            end else begin
              r_cs    <= CH_HI;
              r_pulse <= 1'b1;
              r_cnt   <= r_wid[c] - c_one;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_seq_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_seq_mc
// Brief    : Directed self-checking bench for pulse_seq_mc (4 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_seq_mc;
  localparam int NUM_CH = 4;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_addr = '0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              wr_err;
  logic [NUM_CH-1:0] pulse_out;
  logic              busy;
  logic              done_irq;

  pulse_seq_mc #(.NUM_CH(NUM_CH), .CNT_W(32), .ARM_TIMEOUT(50)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_err(wr_err), .pulse_out(pulse_out), .busy(busy), .done_irq(done_irq)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] tr_p [NUM_CH];
  logic [31:0] tr_busy;
  int          irq_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge ACLK); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(posedge ACLK); #1;
    rd_en = 1'b1; rd_addr = a;
    @(posedge ACLK); #1;
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, rd_data, exp);
  endtask

  // Sample j = cycles after the write edge that carried FIRE.
  task automatic trace(input int n);
    for (int c = 0; c < NUM_CH; c++) tr_p[c] = '0;
    tr_busy = '0;
    irq_cnt = 0;
    for (int j = 1; j <= n; j++) begin
      @(posedge ACLK); #1;
      if (j < 32) begin
        for (int c = 0; c < NUM_CH; c++) tr_p[c][j] = pulse_out[c];
        tr_busy[j] = busy;
      end
      if (done_irq) irq_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    check("reset_pulse", 32'(pulse_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_irq", 32'(done_irq), 32'd0);
    rd_chk("reset_status", 8'h04, 32'h0);
    rd_chk("reset_chen", 8'h08, 32'h0);
    rd_chk("info", 8'h0C, 32'h0002_2004);

    // Single channel: DELAY=3 WIDTH=2 COUNT=1
    wr(8'h10, 32'd3); wr(8'h14, 32'd2); wr(8'h1C, 32'd1); wr(8'h08, 32'h1);
    check("cfg_wr_err", 32'(wr_err), 32'd0);
    wr(8'h00, 32'h1);
    rd_chk("armed_status", 8'h04, 32'h1);
    wr(8'h00, 32'h2);
    trace(16);
    check("single_pulse", tr_p[0], 32'h0000_0030);
    check("single_busy_mid", 32'(tr_busy[5]), 32'd1);
    check("single_irq_cnt", irq_cnt, 32'd1);
    rd_chk("single_status", 8'h04, 32'h4);

    // Repeat: CH1 DELAY=0 WIDTH=2 PERIOD=5 COUNT=3
    wr(8'h20, 32'd0); wr(8'h24, 32'd2); wr(8'h28, 32'd5); wr(8'h2C, 32'd3);
    wr(8'h08, 32'h2);
    wr(8'h00, 32'h1); wr(8'h00, 32'h2);
    trace(20);
    check("rep_p5", tr_p[1], 32'h0000_18C6);
    check("rep_ch0_idle", tr_p[0], 32'h0);
    // PERIOD<=WIDTH gives spacing WIDTH+1
    wr(8'h28, 32'd2);
    wr(8'h00, 32'h1); wr(8'h00, 32'h2);
    trace(16);
    check("rep_p2", tr_p[1], 32'h0000_01B6);

    // Multi-channel stagger, WIDTH=1
    wr(8'h10, 32'd0);  wr(8'h14, 32'd1);
    wr(8'h20, 32'd10); wr(8'h24, 32'd1); wr(8'h2C, 32'd1);
    wr(8'h30, 32'd20); wr(8'h34, 32'd1);
    wr(8'h40, 32'd30); wr(8'h44, 32'd1);
    wr(8'h08, 32'hF);
    wr(8'h00, 32'h1); wr(8'h00, 32'h2);
    trace(40);
    check("multi_ch0", tr_p[0], 32'h0000_0002);
    check("multi_ch1", tr_p[1], 32'h0000_0800);
    check("multi_ch2", tr_p[2], 32'h0020_0000);
    check("multi_ch3", tr_p[3], 32'h8000_0000);
    check("multi_busy_ch3", 32'(tr_busy[31]), 32'd1);
    check("multi_irq_cnt", irq_cnt, 32'd1);
    check("multi_busy_end", 32'(busy), 32'd0);

    // Abort during CH2 high phase (DELAY=20 WIDTH=5)
    wr(8'h34, 32'd5); wr(8'h08, 32'h4);
    wr(8'h00, 32'h1); wr(8'h00, 32'h2);
    trace(22);
    check("abort_pre_high", tr_p[2], 32'h0060_0000);
    wr(8'h00, 32'h4);
    check("abort_pulse", 32'(pulse_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rd_chk("abort_status", 8'h04, 32'h8);
    wr(8'h00, 32'h1);
    rd_chk("rearm_status", 8'h04, 32'h1);

    // Lock while ARMED
    wr(8'h30, 32'h99);
    check("lock_wr_err", 32'(wr_err), 32'd1);
    rd_chk("lock_readback", 8'h30, 32'd20);
    wr(8'h08, 32'h1);
    check("lock_chen_err", 32'(wr_err), 32'd1);
    wr(8'h00, 32'h0);
    check("ctrl_no_err", 32'(wr_err), 32'd0);
    wr(8'h00, 32'h4);
    rd_chk("abort_armed_status", 8'h04, 32'h8);
    wr(8'h04, 32'h1);
    check("status_wr_err", 32'(wr_err), 32'd1);
    wr(8'hFC, 32'h1);
    check("unmapped_wr_err", 32'(wr_err), 32'd1);

    // FIRE in IDLE does nothing
    wr(8'h08, 32'h1);
    check("unlocked_wr_err", 32'(wr_err), 32'd0);
    wr(8'h00, 32'h2);
    trace(8);
    check("idle_fire_pulse", tr_p[0], 32'h0);
    check("idle_fire_busy", tr_busy, 32'h0);

    // ARM with CH_EN=0 stays IDLE (sticky bits still cleared)
    wr(8'h08, 32'h0);
    wr(8'h00, 32'h1);
    rd_chk("arm_noen_status", 8'h04, 32'h0);

    // ARM+FIRE together from IDLE arms only
    wr(8'h08, 32'h1);
    wr(8'h00, 32'h3);
    rd_chk("armfire_status", 8'h04, 32'h1);
    wr(8'h00, 32'h4);

    rd_chk("unmapped_rd", 8'hFC, 32'h0);

    // Reset mid-sequence drops pulse_out without a clock edge
    wr(8'h14, 32'd5);
    wr(8'h00, 32'h1); wr(8'h00, 32'h2);
    trace(2);
    check("pre_reset_high", 32'(pulse_out[0]), 32'd1);
    #3 ARESET = 1'b1;
    #1;
    check("async_reset_pulse", 32'(pulse_out), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    rd_chk("post_reset_width", 8'h14, 32'h0);

`ifdef PULSE_SEQ_ARM_TIMEOUT_EN
    wr(8'h14, 32'd1); wr(8'h08, 32'h1);
    wr(8'h00, 32'h1);
    repeat (55) @(posedge ACLK);
    #1;
    rd_chk("timeout_status", 8'h04, 32'h10);
    wr(8'h00, 32'h2);
    trace(6);
    check("timeout_no_pulse", tr_p[0], 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
